router_out_arbiter: RTL and testbench
=====================================

Name: router_out_arbiter

Overview:
- Drains the three router output FIFOs onto one shared 8-bit downstream link, one whole packet at a time.
- Round-robin arbitration among ports with vld_out high.
- Drives read_enb_0..2 and parses each header byte for the payload length.
- Tags the outgoing beats with source port, start-of-packet and end-of-packet.
- Sits between the router outputs (vld_out_x/dout_out_x) and the downstream link.

Parameters:
- DATA_W, 8, byte width of FIFO data and link data.
- LEN_W, 6, header length field width (header[7:2] = payload length, header[1:0] = address).
- STALL_MAX, 255, consecutive starved cycles on the granted port before the packet is aborted.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- vld_out_0/1/2  in  1 each  FIFO non-empty from the router.
- dout_out_0/1/2  in  DATA_W each  FIFO read data; valid the cycle after read_enb.
- read_enb_0/1/2  out  1 each  FIFO read strobe.
- link_ready  in  1  credit: high at cycle t guarantees acceptance of a beat presented at t+1.
- link_valid  out  1  beat present on link_data.
- link_data  out  DATA_W  beat; forced to 0 when link_valid=0.
- link_sop  out  1  beat is a header.
- link_eop  out  1  beat is the parity byte.
- link_port  out  2  source port of the current packet.
- link_abort  out  1  one-cycle pulse: packet truncated.

Behaviour:
- Reset: asynchronous, active-low; clock and reset as stated above.
  - All outputs 0; state IDLE; rr pointer = 0; remaining = 0; stall counter = 0.
  - Reset mid-packet truncates silently; no abort pulse.
- Issue rule: read_enb_g = granted & issuing-state & vld_out_g & link_ready & remaining>0 (header counts as one). Non-granted read_enb are always 0.
- A FIFO is never read while empty.
- Beat emission: link_valid is a registered copy of "read issued last cycle". link_data = dout_out_g, muxed combinationally.
- IDLE: if any vld_out is set, pick the first in order rr, rr+1, rr+2 (mod 3). Latch grant g and link_port=g, then go to HDR.
- HDR: issue the header read when vld_out_g & link_ready, then go to HLEN.
- HLEN: header beat presented with link_sop=1.
  - Capture len = dout_out_g[7:2]; remaining = len+1 (payload + parity).
  - May issue the next read in the same cycle using the captured length combinationally, giving back-to-back throughput.
  - Go to XFER.
- XFER:
  - Each issued read decrements remaining.
  - The issue that takes remaining 1→0 marks the following beat with link_eop=1; then go to DONE.
  - link_ready low: no issue and no beat loss; the in-flight beat is still presented.
- DONE: last beat presented; rr = (g+1) mod 3; go to IDLE.
  - One idle cycle between packets is acceptable.
- Starvation:
  - In HDR/XFER with vld_out_g=0, the stall counter increments; any issue clears it.
  - Counter reaching STALL_MAX: pulse link_abort for 1 cycle; no eop; rr = g+1; go to IDLE.
  - link_ready low does not count as starvation.
- len=0: exactly 2 beats (header sop, parity eop). sop and eop are never asserted on the same beat.
- vld_out of non-granted ports may toggle freely; this only affects the next IDLE decision.
- Maximum packet length is 65 beats. Non-granted ports wait up to ~67 cycles; the router's 30-cycle soft reset can flush them, which is a system-level property and is not masked here.
- Simultaneous: when a packet finishes and a new request arrives in DONE, the request is considered in the next IDLE, using the updated rr.

Decomposition:
- Shared package router_pkg holds:
  - state enum (IDLE, HDR, HLEN, XFER, DONE);
  - header field positions LEN_MSB/LEN_LSB/ADDR;
  - port-count constant 3.
- Sub-module router_rr_pick: combinational 3-way round-robin picker (req[2:0], rr → grant one-hot + index). All state stays in the top.

Test Plan:
- Port 1 holds 0x0D,0xA1,0xA2,0xA3,0x0F with link_ready=1.
  - Response: read_enb_1 high 5 consecutive cycles after HDR; 5 beats out.
  - sop on 0x0D, eop on 0x0F, link_port=1, rr ends at 2.
- All three ports valid right after reset, each with a len=2 packet.
  - Response: packets out in order port 0,1,2; link_port 0→1→2.
  - rr=0 on exit; no interleaving of beats.
- Port 2 header 0x02 (len 0) plus parity 0x02.
  - Response: exactly two beats, sop then eop; remaining never underflows.
- len=4 packet with link_ready held low for 3 cycles mid-XFER.
  - Response: no read_enb during the hold; all 6 beats delivered exactly once, in order.
- Granted port's vld_out drops for 10 cycles mid-payload, then resumes.
  - Response: stall, no abort, packet completes.
- Same drop held for STALL_MAX cycles.
  - Response: link_abort pulses once, no eop, next port served.
- resetn pulsed low mid-XFER.
  - Response: all outputs 0 asynchronously, rr=0, IDLE on release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router output arbiter.
package router_pkg;

  localparam int NUM_PORTS = 3;

  // Header byte layout: payload length above, destination address below.
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HLEN,
    XFER,
    DONE
  } state_t;

  // Reduces a small sum of port indices back into 0..NUM_PORTS-1.
  function automatic logic [1:0] port_wrap(input logic [2:0] sum);
    return (sum >= 3'(NUM_PORTS)) ? 2'(sum - 3'(NUM_PORTS)) : sum[1:0];
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr, wrapping
// over the three ports.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           rr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [1:0]           idx,
  output logic                 any
);

  logic [1:0]           cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
      assign cand[gi] = port_wrap(3'(rr) + 3'(gi));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Lowest rotation offset wins.
  always_comb begin
    idx = cand[2];
    if (hit[1]) idx = cand[1];
    if (hit[0]) idx = cand[0];
  end

  assign any   = |hit;
  assign grant = any ? (NUM_PORTS'(1) << idx) : '0;

endmodule

// File: rtl/router_out_arbiter.sv
// Drains the three router output FIFOs onto one shared byte link, a whole
// packet at a time, with round-robin fairness and starvation abort.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 6,
  parameter int STALL_MAX = 255
)(
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out_0,
  input  logic              vld_out_1,
  input  logic              vld_out_2,
  input  logic [DATA_W-1:0] dout_out_0,
  input  logic [DATA_W-1:0] dout_out_1,
  input  logic [DATA_W-1:0] dout_out_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  input  logic              link_ready,
  output logic              link_valid,
  output logic [DATA_W-1:0] link_data,
  output logic              link_sop,
  output logic              link_eop,
  output logic [1:0]        link_port,
  output logic              link_abort
);

  localparam int REM_W   = LEN_W + 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  state_t               state_reg, state_next;
  logic [1:0]           grant_reg, grant_next;
  logic [NUM_PORTS-1:0] grant_oh_reg, grant_oh_next;
  logic [1:0]           rr_reg, rr_next;
  logic [REM_W-1:0]     remaining_reg, remaining_next;
  logic [STALL_W-1:0]   stall_reg, stall_next;
  logic                 valid_reg, valid_next;
  logic                 sop_reg, sop_next;
  logic                 eop_reg, eop_next;
  logic                 abort_reg, abort_next;

  logic [NUM_PORTS-1:0] vld_vec, pick_grant, rd_vec;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic                 vld_g;
  logic [DATA_W-1:0]    dout_g;
  logic [LEN_W-1:0]     hdr_len;
  logic [REM_W-1:0]     avail;
  logic                 issue, starved, stall_hit;

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};

  router_rr_pick u_pick (
    .req   (vld_vec),
    .rr    (rr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    case (grant_reg)
      2'd1:    begin vld_g = vld_out_1; dout_g = dout_out_1; end
      2'd2:    begin vld_g = vld_out_2; dout_g = dout_out_2; end
      default: begin vld_g = vld_out_0; dout_g = dout_out_0; end
    endcase
  end

  assign hdr_len = LEN_W'(dout_g[LEN_MSB:LEN_LSB]);

  // Reads still owed: the header counts as one; in HLEN the length comes
  // straight off the header beat so the first payload read is not delayed.
  always_comb begin
    case (state_reg)
      HDR:     avail = REM_W'(1);
      HLEN:    avail = REM_W'(hdr_len) + REM_W'(1);
      XFER:    avail = remaining_reg;
      default: avail = '0;
    endcase
  end

  assign issue     = (avail != '0) && vld_g && link_ready;
  assign starved   = ((state_reg == HDR) || (state_reg == XFER)) && !vld_g && link_ready;
  assign stall_hit = (stall_reg == STALL_W'(STALL_MAX - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_oh_reg  <= '0;
      rr_reg        <= '0;
      remaining_reg <= '0;
      stall_reg     <= '0;
      valid_reg     <= 1'b0;
      sop_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      grant_oh_reg  <= grant_oh_next;
      rr_reg        <= rr_next;
      remaining_reg <= remaining_next;
      stall_reg     <= stall_next;
      valid_reg     <= valid_next;
      sop_reg       <= sop_next;
      eop_reg       <= eop_next;
      abort_reg     <= abort_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    grant_oh_next  = grant_oh_reg;
    rr_next        = rr_reg;
    remaining_next = remaining_reg;
    stall_next     = stall_reg;
    valid_next     = issue;
    sop_next       = issue && (state_reg == HDR);
    eop_next       = 1'b0;
    abort_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        remaining_next = '0;
        stall_next     = '0;
        if (pick_any) begin
          grant_next    = pick_idx;
          grant_oh_next = pick_grant;
          state_next    = HDR;
        end
      end
      HDR: begin
        if (issue) begin
          stall_next = '0;
          state_next = HLEN;
        end
      end
      HLEN: begin
        remaining_next = avail - REM_W'(issue);
        stall_next     = '0;
        if (issue && (avail == REM_W'(1))) begin
          eop_next   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (issue) begin
          remaining_next = remaining_reg - REM_W'(1);
          stall_next     = '0;
          if (remaining_reg == REM_W'(1)) begin
            eop_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        rr_next    = port_wrap(3'(grant_reg) + 3'd1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (starved) begin
      if (stall_hit) begin
        abort_next     = 1'b1;
        stall_next     = '0;
        remaining_next = '0;
        rr_next        = port_wrap(3'(grant_reg) + 3'd1);
        state_next     = IDLE;
      end else begin
        stall_next = stall_reg + STALL_W'(1);
      end
    end
  end

  always_comb begin
    rd_vec = '0;
    if (issue) rd_vec = grant_oh_reg;
    link_data = valid_reg ? dout_g : '0;
  end

  assign read_enb_0 = rd_vec[0];
  assign read_enb_1 = rd_vec[1];
  assign read_enb_2 = rd_vec[2];
  assign link_valid = valid_reg;
  assign link_sop   = sop_reg;
  assign link_eop   = eop_reg;
  assign link_port  = grant_reg;
  assign link_abort = abort_reg;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench: FIFO models feed the arbiter, an expected-beat queue built
// from packet descriptions is checked against the link every cycle.
module tb_router_out_arbiter;

  localparam int STALL_MAX = 255;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] dout_out_0, dout_out_1, dout_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       link_ready;
  logic       link_valid;
  logic [7:0] link_data;
  logic       link_sop, link_eop, link_abort;
  logic [1:0] link_port;

  always #5 clock = ~clock;

  router_out_arbiter #(.DATA_W(8), .LEN_W(6), .STALL_MAX(STALL_MAX)) dut (
    .clock(clock), .resetn(resetn),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .dout_out_0(dout_out_0), .dout_out_1(dout_out_1), .dout_out_2(dout_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .link_ready(link_ready), .link_valid(link_valid), .link_data(link_data),
    .link_sop(link_sop), .link_eop(link_eop), .link_port(link_port),
    .link_abort(link_abort)
  );

  // FIFO models: data appears the cycle after the read strobe.
  logic [7:0] fmem [3][256];
  int         fhead [3];
  int         ftail [3];
  logic [7:0] fdout [3];

  assign vld_out_0  = (fhead[0] != ftail[0]);
  assign vld_out_1  = (fhead[1] != ftail[1]);
  assign vld_out_2  = (fhead[2] != ftail[2]);
  assign dout_out_0 = fdout[0];
  assign dout_out_1 = fdout[1];
  assign dout_out_2 = fdout[2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
    logic [1:0] port;
    bit         abort;
  } exp_t;
  exp_t expq[$];

  bit         chk_en = 1'b0;
  int         beats_seen = 0, eop_seen = 0, abort_seen = 0;
  int         run1 = 0, max_run1 = 0;
  int         sop_ports[$];
  logic [7:0] last_sop_data, last_eop_data;

  initial begin
    for (int p = 0; p < 3; p++) begin
      fhead[p] = 0;
      ftail[p] = 0;
      fdout[p] = 8'h00;
    end
  end

  always @(posedge clock) begin
    logic [2:0] rd;
    rd = {read_enb_2, read_enb_1, read_enb_0};
    for (int p = 0; p < 3; p++) begin
      if (rd[p]) begin
        total++;
        if (fhead[p] == ftail[p]) begin
          bad++;
          $display("FAIL empty_read port=%0d", p);
        end else begin
          fdout[p] <= fmem[p][fhead[p] % 256];
          fhead[p] <= fhead[p] + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [2:0] rd;
    exp_t       e;
    if (chk_en) begin
      rd = {read_enb_2, read_enb_1, read_enb_0};
      total++;
      if ($countones(rd) > 1 || (rd != 3'b000 && !link_ready)) begin
        bad++;
        $display("FAIL read_rule got rd=%b ready=%b need one-hot strobe with ready", rd, link_ready);
      end
      if (read_enb_1) run1++; else run1 = 0;
      if (run1 > max_run1) max_run1 = run1;
      total++;
      if (!link_valid) begin
        if (link_data != 8'h00 || link_sop || link_eop) begin
          bad++;
          $display("FAIL idle_link got data=%02h sop=%b eop=%b need all 0", link_data, link_sop, link_eop);
        end
      end else begin
        beats_seen++;
        if (link_eop) begin
          eop_seen++;
          last_eop_data = link_data;
        end
        if (link_sop) begin
          sop_ports.push_back(int'(link_port));
          last_sop_data = link_data;
        end
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got data=%02h port=%0d need none", link_data, link_port);
        end else begin
          e = expq.pop_front();
          if (e.abort || e.d !== link_data || e.sop !== link_sop || e.eop !== link_eop || e.port !== link_port) begin
            bad++;
            $display("FAIL beat got data=%02h sop=%b eop=%b port=%0d need data=%02h sop=%b eop=%b port=%0d abort=%b",
                     link_data, link_sop, link_eop, link_port, e.d, e.sop, e.eop, e.port, e.abort);
          end
        end
      end
      if (link_abort) begin
        abort_seen++;
        total++;
        if (expq.size() == 0 || !expq[0].abort) begin
          bad++;
          $display("FAIL unexpected_abort got abort=1 need 0");
        end else begin
          void'(expq.pop_front());
        end
      end
    end
  end

  logic [7:0] pkt_b [70];
  int         pkt_n;

  // Packet = header, len payload bytes, XOR parity byte: len+2 beats.
  task automatic make_pkt(input logic [7:0] hdr, input logic [7:0] seed);
    logic [7:0] par;
    pkt_n    = int'(hdr[7:2]) + 2;
    pkt_b[0] = hdr;
    par      = hdr;
    for (int i = 1; i < pkt_n - 1; i++) begin
      pkt_b[i] = seed + 8'(i);
      par      = par ^ pkt_b[i];
    end
    pkt_b[pkt_n-1] = par;
  endtask

  task automatic load(input int p, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      fmem[p][ftail[p] % 256] = pkt_b[i];
      ftail[p]++;
    end
  endtask

  task automatic expect_beats(input int p, input int n);
    for (int i = 0; i < n; i++)
      expq.push_back('{d: pkt_b[i], sop: (i == 0), eop: (i == pkt_n - 1), port: 2'(p), abort: 1'b0});
  endtask

  task automatic expect_abort();
    expq.push_back('{d: 8'h00, sop: 1'b0, eop: 1'b0, port: 2'd0, abort: 1'b1});
  endtask

  task automatic send(input int p, input logic [7:0] hdr, input logic [7:0] seed);
    make_pkt(hdr, seed);
    load(p, 0, pkt_n);
    expect_beats(p, pkt_n);
  endtask

  task automatic check(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got %0d beats pending need 0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (beats_seen < target) begin
      total++;
      bad++;
      $display("FAIL beat_timeout got %0d beats need %0d", beats_seen, target);
    end
  endtask

  function automatic int out_vec();
    return int'({link_data, link_port, link_valid, link_sop, link_eop, link_abort,
                 read_enb_2, read_enb_1, read_enb_0});
  endfunction

  function automatic int order_code();
    int c = 0;
    foreach (sop_ports[i]) c = c * 10 + sop_ports[i] + 1;
    return c;
  endfunction

  // Asynchronous reset between clock edges, then flush all bench state.
  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clock);
    #2 resetn = 1'b0;
    #1 check("reset_async_outputs", out_vec(), 0);
    for (int p = 0; p < 3; p++) ftail[p] = fhead[p];
    expq.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
  endtask

  int b0, e0, a0;

  initial begin
    link_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", out_vec(), 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);

    // Port 1 fixed packet 0D A1 A2 A3 0F.
    b0 = beats_seen; max_run1 = 0;
    pkt_b[0] = 8'h0D; pkt_b[1] = 8'hA1; pkt_b[2] = 8'hA2; pkt_b[3] = 8'hA3; pkt_b[4] = 8'h0F;
    pkt_n = 5;
    load(1, 0, 5);
    expect_beats(1, 5);
    wait_drain(100);
    check("t1_beats", beats_seen - b0, 5);
    check("t1_rd1_run", max_run1, 5);
    check("t1_sop_byte", int'(last_sop_data), 8'h0D);
    check("t1_eop_byte", int'(last_eop_data), 8'h0F);

    // All ports after reset: served 0,1,2.
    do_reset();
    b0 = beats_seen; sop_ports.delete();
    send(0, 8'h08, 8'h10);
    send(1, 8'h09, 8'h20);
    send(2, 8'h0A, 8'h30);
    wait_drain(200);
    check("t2_beats", beats_seen - b0, 12);
    check("t2_order", order_code(), 123);

    // rr back at 0: ports 2 and 1 pending, port 1 must win.
    sop_ports.delete();
    send(1, 8'h05, 8'h38);
    send(2, 8'h06, 8'h3C);
    wait_drain(200);
    check("t2_rr_order", order_code(), 23);

    // len=0 on port 2.
    b0 = beats_seen; e0 = eop_seen;
    send(2, 8'h02, 8'h00);
    wait_drain(100);
    check("t3_beats", beats_seen - b0, 2);
    check("t3_eops", eop_seen - e0, 1);

    // len=4 with link_ready low for three cycles mid-payload.
    b0 = beats_seen;
    send(0, 8'h10, 8'h40);
    wait_beats(b0 + 2, 50);
    link_ready = 1'b0;
    repeat (3) @(negedge clock);
    link_ready = 1'b1;
    wait_drain(100);
    check("t4_beats", beats_seen - b0, 6);

    // Granted port runs dry for 10 cycles, then resumes.
    b0 = beats_seen; a0 = abort_seen;
    make_pkt(8'h0C, 8'h50);
    load(1, 0, 2);
    expect_beats(1, pkt_n);
    wait_beats(b0 + 2, 50);
    repeat (10) @(negedge clock);
    load(1, 2, pkt_n);
    wait_drain(100);
    check("t5_beats", beats_seen - b0, 5);
    check("t5_aborts", abort_seen - a0, 0);

    // Granted port starved until abort; port 1 served next.
    b0 = beats_seen; a0 = abort_seen; e0 = eop_seen;
    make_pkt(8'h10, 8'h60);
    load(0, 0, 2);
    expect_beats(0, 2);
    expect_abort();
    make_pkt(8'h05, 8'h70);
    load(1, 0, pkt_n);
    expect_beats(1, pkt_n);
    wait_drain(STALL_MAX + 100);
    check("t6_aborts", abort_seen - a0, 1);
    check("t6_eops", eop_seen - e0, 1);
    check("t6_beats", beats_seen - b0, 5);

    // Reset mid-packet with rr at 1; afterwards port 0 must win again.
    send(0, 8'h01, 8'h00);
    wait_drain(100);
    b0 = beats_seen;
    make_pkt(8'h15, 8'h80);
    load(1, 0, pkt_n);
    expect_beats(1, pkt_n);
    wait_beats(b0 + 3, 50);
    a0 = abort_seen;
    do_reset();
    sop_ports.delete();
    send(0, 8'h04, 8'hA0);
    send(1, 8'h05, 8'hB0);
    wait_drain(200);
    check("t7_order", order_code(), 12);
    check("t7_no_abort", abort_seen - a0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
